// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction-fetch unit
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    OUT,
    WB,
    ERR
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] NOP_INS          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_axil_fetch_perf_counter.sv
// rtl/ifu_axil_fetch_perf_counter.sv - free-running wrap-around event counter
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/ifu_axil_fetch.sv
// rtl/ifu_axil_fetch.sv - multicycle fetch stage: one AXI-Lite read at a time, then
// hand the instruction to decode and wait for writeback's next PC
module ifu_axil_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      ins,
  output logic [31:0]      pc,
  output logic             ins_valid,
  input  logic             ins_ready,
  input  logic [31:0]      dnpc,
  input  logic             dnpc_valid,
  output logic             fetch_err,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  ifu_state_e state, state_nxt;
  logic ins_load, pc_load, set_fetch_err, set_misalign;
  logic fetch_done, stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    arvalid       = 1'b0;
    rready        = 1'b0;
    ins_valid     = 1'b0;
    ins_load      = 1'b0;
    pc_load       = 1'b0;
    set_fetch_err = 1'b0;
    set_misalign  = 1'b0;
    fetch_done    = 1'b0;
    stall         = 1'b0;
    case (state)
      IDLE: state_nxt = AR;
      AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = R;
        end else begin
          stall = 1'b1;
        end
      end
      R: begin
        rready = 1'b1;
        if (!rvalid) begin
          stall = 1'b1;
        end else if (rresp == RESP_OKAY) begin
          ins_load  = 1'b1;
          state_nxt = OUT;
        end else begin
          set_fetch_err = 1'b1;
          state_nxt     = ERR;
        end
      end
      OUT: begin
        ins_valid = 1'b1;
        if (ins_ready) begin
          fetch_done = 1'b1;
          state_nxt  = WB;
        end
      end
      WB: begin
        // The PC is taken even when misaligned so the faulting target stays visible.
        if (dnpc_valid) begin
          pc_load = 1'b1;
          if (dnpc[1:0] != 2'b00) begin
            set_misalign = 1'b1;
            state_nxt    = ERR;
          end else begin
            state_nxt = AR;
          end
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      ins          <= NOP_INS;
      fetch_err    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (pc_load) begin
        pc <= dnpc;
      end
      if (ins_load) begin
        ins <= rdata;
      end
      if (set_fetch_err) begin
        fetch_err <= 1'b1;
      end
      if (set_misalign) begin
        misalign_err <= 1'b1;
      end
    end
  end

  assign araddr = pc;

  perf_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fetch_done),
    .cnt (fetch_cnt)
  );

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_ifu_axil_fetch.sv
// tb/tb_ifu_axil_fetch.sv - randomized bench for ifu_axil_fetch against a
// transaction-level protocol model
module tb_ifu_axil_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] dnpc;
  logic        dnpc_valid;
  logic        fetch_err;
  logic        misalign_err;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  ifu_axil_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .ins          (ins),
    .pc           (pc),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .dnpc         (dnpc),
    .dnpc_valid   (dnpc_valid),
    .fetch_err    (fetch_err),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model of architectural state
  logic [31:0] m_pc, m_ins, m_fcnt, m_scnt;
  logic        m_ferr, m_merr;

  // stimulus knobs; a delay of -1 means random peer behaviour
  int          ar_delay, r_delay, out_delay, wb_delay, resp_force;
  int          dnpc_mode, resp_err_pct, mis_pct;
  bit          rdata_fixed_en, abort_in_r;
  logic [31:0] rdata_fixed, dnpc_fixed;
  logic [31:0] addr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input logic av, input logic rr, input logic iv);
    chk("arvalid", arvalid, av);
    chk("rready", rready, rr);
    chk("ins_valid", ins_valid, iv);
    chk("araddr", araddr, m_pc);
    chk("pc", pc, m_pc);
    chk("ins", ins, m_ins);
    chk("fetch_err", fetch_err, m_ferr);
    chk("misalign_err", misalign_err, m_merr);
    chk("fetch_cnt", fetch_cnt, m_fcnt);
    chk("stall_cnt", stall_cnt, m_scnt);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive();
    logic [31:0] r;
    int p;
    r         = $urandom;
    arready   = ($urandom_range(99) < 60);
    rvalid    = ($urandom_range(99) < 60);
    rdata     = rdata_fixed_en ? rdata_fixed : r;
    rresp     = ($urandom_range(99) < resp_err_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
    ins_ready = ($urandom_range(99) < 60);
    dnpc_valid = ($urandom_range(99) < 60);
    r = $urandom;
    case (dnpc_mode)
      1: dnpc = m_pc + 32'd4;
      2: dnpc = dnpc_fixed;
      default: begin
        p = $urandom_range(99);
        if (p < mis_pct) dnpc = m_pc + 32'd4 + 32'($urandom_range(3, 1));
        else if (p < 70) dnpc = m_pc + 32'd4;
        else dnpc = {r[31:2], 2'b00};
      end
    endcase
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ins = 32'h0000_0013; m_fcnt = 0; m_scnt = 0;
    m_ferr = 1'b0; m_merr = 1'b0;
  endtask

  task automatic set_fast();
    ar_delay = 0; r_delay = 0; out_delay = 0; wb_delay = 0; resp_force = 0;
    dnpc_mode = 1; resp_err_pct = 0; mis_pct = 0;
    rdata_fixed_en = 1'b1; rdata_fixed = 32'h0010_0093; abort_in_r = 1'b0;
  endtask

  task automatic set_random();
    ar_delay = -1; r_delay = -1; out_delay = -1; wb_delay = -1; resp_force = -1;
    dnpc_mode = 0; resp_err_pct = 3; mis_pct = 2;
    rdata_fixed_en = 1'b0; abort_in_r = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive();
    repeat (2) tick();
    rst = 1'b1;
    model_reset();
    addr_log.delete();
  endtask

  // first cycle after release: reset values, no request yet
  task automatic start();
    check_outs(1'b0, 1'b0, 1'b0);
    drive();
    tick();
  endtask

  task automatic err_phase();
    for (int i = 0; i < 8; i++) begin
      check_outs(1'b0, 1'b0, 1'b0);
      drive();
      tick();
    end
  endtask

  // status: 0 = all fetched, 1 = ended in error, 2 = stopped in R for an abort
  task automatic run_txns(input int n, output int status);
    bit hs;
    int k;
    status = 0;
    for (int t = 0; t < n; t++) begin
      k = 0; hs = 0;
      while (!hs) begin
        check_outs(1'b1, 1'b0, 1'b0);
        if (k == 0) addr_log.push_back(araddr);
        drive();
        if (ar_delay >= 0) arready = (k >= ar_delay);
        hs = arready;
        if (!hs) m_scnt++;
        tick(); k++;
      end
      k = 0; hs = 0;
      while (!hs) begin
        check_outs(1'b0, 1'b1, 1'b0);
        drive();
        if (r_delay >= 0) rvalid = (k >= r_delay);
        if (resp_force >= 0) rresp = 2'(resp_force);
        if (abort_in_r && t == 1) begin
          rvalid = (k == 2);
          if (k == 2) begin
            status = 2;
            return;
          end
        end
        hs = rvalid;
        if (!hs) m_scnt++;
        else if (rresp == 2'b00) m_ins = rdata;
        else m_ferr = 1'b1;
        tick(); k++;
      end
      if (m_ferr) begin
        err_phase();
        status = 1;
        return;
      end
      k = 0; hs = 0;
      while (!hs) begin
        check_outs(1'b0, 1'b0, 1'b1);
        drive();
        if (out_delay >= 0) begin
          ins_ready  = (k >= out_delay);
          dnpc_valid = (k == 2);
          dnpc       = 32'hDEAD_BEE0;
        end
        hs = ins_ready;
        if (hs) m_fcnt++;
        tick(); k++;
      end
      k = 0; hs = 0;
      while (!hs) begin
        check_outs(1'b0, 1'b0, 1'b0);
        drive();
        if (wb_delay >= 0) dnpc_valid = (k >= wb_delay);
        hs = dnpc_valid;
        if (hs) begin
          m_pc = dnpc;
          if (dnpc[1:0] != 2'b00) m_merr = 1'b1;
        end
        tick(); k++;
      end
      if (m_merr) begin
        err_phase();
        status = 1;
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int c0;
    rst = 1'b0;
    set_fast();
    model_reset();
    drive();

    // back-to-back fetches with instant peers
    do_reset();
    c0 = cyc;
    start();
    run_txns(3, st);
    chk("t1_cycles", 32'(cyc - c0), 32'd13);
    chk("t1_addr0", addr_log[0], 32'h8000_0000);
    chk("t1_addr1", addr_log[1], 32'h8000_0004);
    chk("t1_addr2", addr_log[2], 32'h8000_0008);
    chk("t1_fetch_cnt", fetch_cnt, 32'd3);
    chk("t1_stall_cnt", stall_cnt, 32'd0);
    chk("t1_araddr", araddr, 32'h8000_000C);
    chk("t1_ins", ins, 32'h0010_0093);

    // slow memory: 3 cycles without arready, 2 without rvalid
    set_fast();
    ar_delay = 3; r_delay = 2; rdata_fixed = 32'hCAFE_0093;
    do_reset();
    start();
    run_txns(1, st);
    chk("t2_stall_cnt", stall_cnt, 32'd5);
    chk("t2_ins", ins, 32'hCAFE_0093);
    chk("t2_fetch_cnt", fetch_cnt, 32'd1);

    // decode stalls 6 cycles; a dnpc_valid pulse lands during OUT
    set_fast();
    out_delay = 6;
    do_reset();
    c0 = cyc;
    start();
    run_txns(1, st);
    chk("t3_cycles", 32'(cyc - c0), 32'd11);
    chk("t3_pc", pc, 32'h8000_0004);

    // bus error on the first fetch
    set_fast();
    resp_force = 2;
    do_reset();
    start();
    run_txns(1, st);
    chk("t4_fetch_err", fetch_err, 32'd1);
    chk("t4_ins", ins, 32'h0000_0013);
    chk("t4_arvalid", arvalid, 32'd0);

    // misaligned next PC
    set_fast();
    dnpc_mode = 2; dnpc_fixed = 32'h8000_0102;
    do_reset();
    start();
    run_txns(2, st);
    chk("t5_misalign_err", misalign_err, 32'd1);
    chk("t5_pc", pc, 32'h8000_0102);
    chk("t5_arvalid", arvalid, 32'd0);
    chk("t5_fetch_cnt", fetch_cnt, 32'd1);

    // asynchronous reset while a read response is pending
    set_fast();
    rdata_fixed = 32'h1234_5677; abort_in_r = 1'b1;
    do_reset();
    start();
    run_txns(2, st);
    chk("t6_reached_r", rready, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_arvalid", arvalid, 32'd0);
    chk("t6_rready", rready, 32'd0);
    chk("t6_ins_valid", ins_valid, 32'd0);
    chk("t6_pc", pc, 32'h8000_0000);
    chk("t6_ins", ins, 32'h0000_0013);
    chk("t6_fetch_cnt", fetch_cnt, 32'd0);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    addr_log.delete();
    set_fast();
    start();
    run_txns(1, st);
    chk("t6_first_addr", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF, 32'h8000_0000);

    // randomized peers, noise on unconsumed inputs, occasional errors
    for (int s = 0; s < 6; s++) begin
      set_random();
      do_reset();
      start();
      run_txns(40, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
